// File: rtl/pe_sad.sv
// pe_sad: systolic SAD processing element with pixel forwarding and selectable distance metric
// Ports: clk, rst_n (async active-low); en_sw/en_tb + pel_sw/pel_tb load the forwarded
// pixel registers nxt_sw/nxt_tb; ad is their distance under the latched mode; start/acc_en
// drive block accumulation into sad, with sad_valid pulsing on completion and busy in ACC.
module pe_sad #(
  parameter int PW   = 8,
  parameter int NPIX = 256,
  parameter int SADW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_sw,
  input  logic            en_tb,
  input  logic [PW-1:0]   pel_sw,
  input  logic [PW-1:0]   pel_tb,
  output logic [PW-1:0]   nxt_sw,
  output logic [PW-1:0]   nxt_tb,
  input  logic [1:0]      mode,
  input  logic            start,
  input  logic            acc_en,
  output logic [PW-1:0]   ad,
  output logic [SADW-1:0] sad,
  output logic            sad_valid,
  output logic            busy
);
  localparam int H  = PW / 2;
  localparam int CW = $clog2(NPIX) + 1;
  typedef enum logic {IDLE, ACC} state_t;
  state_t          r_state, w_next;
  logic [PW-1:0]   r_sw, r_tb;
  logic [1:0]      r_mode;
  logic [SADW-1:0] r_sad;
  logic [CW-1:0]   r_count;
  logic            r_valid;
  logic [PW-1:0]   w_full, w_half, w_hyb;
  logic [H-1:0]    w_hs, w_ht;
  logic [1:0]      w_ms, w_mt;
  logic [SADW:0]   w_sum;
  logic [SADW-1:0] w_sat;
  logic            w_last;
  always_comb begin
    w_hs   = r_sw[PW-1:H];
    w_ht   = r_tb[PW-1:H];
    w_ms   = r_sw[PW-1:PW-2];
    w_mt   = r_tb[PW-1:PW-2];
    w_full = r_sw >= r_tb ? r_sw - r_tb : r_tb - r_sw;
    w_half = {{(PW-H){1'b0}}, w_hs >= w_ht ? w_hs - w_ht : w_ht - w_hs};
    w_hyb  = {w_ms >= w_mt ? w_ms - w_mt : w_mt - w_ms, r_sw[PW-3:0] ^ r_tb[PW-3:0]};
    ad     = r_mode == 2'd1 ? w_half : r_mode == 2'd2 ? w_hyb : w_full;
  end
  // one extra bit catches the carry so the sum clamps instead of wrapping
  always_comb begin
    w_sum  = {1'b0, r_sad} + (SADW+1)'(ad);
    w_sat  = w_sum[SADW] ? '1 : w_sum[SADW-1:0];
    w_last = r_state == ACC && acc_en && !start && r_count == CW'(NPIX-1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb
    w_next = start ? ACC : w_last ? IDLE : r_state;
  always_comb
    busy = r_state == ACC;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw    <= '0;
      r_tb    <= '0;
      r_mode  <= '0;
      r_sad   <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      if (en_sw) r_sw <= pel_sw;
      if (en_tb) r_tb <= pel_tb;
      r_valid <= w_last;
      if (start) begin
        r_mode  <= mode;
        r_sad   <= '0;
        r_count <= '0;
      end else if (r_state == ACC && acc_en) begin
        r_sad   <= w_sat;
        r_count <= w_last ? r_count : r_count + 1'b1;
      end
    end
  end
  assign nxt_sw    = r_sw;
  assign nxt_tb    = r_tb;
  assign sad       = r_sad;
  assign sad_valid = r_valid;
endmodule

// File: tb/tb_pe_sad.sv
// tb_pe_sad: scoreboard bench for pe_sad (NPIX=4) with a second SADW=9 instance for saturation
module tb_pe_sad;
  logic        clk = 0, rst_n = 0;
  logic        en_sw = 0, en_tb = 0, start = 0, acc_en = 0;
  logic [7:0]  pel_sw = 0, pel_tb = 0;
  logic [1:0]  mode = 0;
  logic [7:0]  nxt_sw, nxt_tb, ad, s_nsw, s_ntb, s_ad;
  logic [15:0] sad;
  logic [8:0]  s_sad;
  logic        sad_valid, busy, s_valid, s_busy;
  int          n_pass = 0, n_tot = 0;
  int          q[$];
  always #5 clk = ~clk;
  pe_sad #(.PW(8), .NPIX(4), .SADW(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .en_sw(en_sw), .en_tb(en_tb), .pel_sw(pel_sw), .pel_tb(pel_tb),
    .nxt_sw(nxt_sw), .nxt_tb(nxt_tb), .mode(mode), .start(start), .acc_en(acc_en),
    .ad(ad), .sad(sad), .sad_valid(sad_valid), .busy(busy));
  pe_sad #(.PW(8), .NPIX(4), .SADW(9)) u_sat (
    .clk(clk), .rst_n(rst_n), .en_sw(en_sw), .en_tb(en_tb), .pel_sw(pel_sw), .pel_tb(pel_tb),
    .nxt_sw(s_nsw), .nxt_tb(s_ntb), .mode(mode), .start(start), .acc_en(acc_en),
    .ad(s_ad), .sad(s_sad), .sad_valid(s_valid), .busy(s_busy));
  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load(input int sw, input int tb);
    pel_sw = 8'(sw); pel_tb = 8'(tb); en_sw = 1; en_tb = 1;
    tick;
    en_sw = 0; en_tb = 0;
  endtask
  task automatic go(input int m);
    mode = 2'(m); start = 1;
    tick;
    start = 0;
  endtask
  task automatic acc(input int n);
    acc_en = 1;
    repeat (n) tick;
    acc_en = 0;
  endtask
  initial begin
    fork
      forever begin
        @(negedge clk);
        if (sad_valid) begin
          if (q.size() == 0) chk("unexpected_sad_valid", int'(sad), -1);
          else chk("scoreboard_sad", int'(sad), q.pop_front());
        end
      end
    join_none
    #12;
    chk("rst_sad", int'(sad), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_nxt_sw", int'(nxt_sw), 0);
    rst_n = 1;
    tick;
    load(200, 50);
    chk("m0_ad", int'(ad), 150);
    q.push_back(600);
    go(0);
    chk("start_busy", int'(busy), 1);
    chk("start_sad", int'(sad), 0);
    acc(4);
    chk("m0_valid", int'(sad_valid), 1);
    chk("m0_busy_fall", int'(busy), 0);
    tick;
    chk("valid_one_cycle", int'(sad_valid), 0);
    load(8'hF3, 8'h1C);
    q.push_back(56);
    go(1);
    chk("m1_ad", int'(ad), 8'h0E);
    acc(4);
    load(8'hC5, 8'h4A);
    q.push_back(572);
    go(2);
    chk("m2_ad", int'(ad), 8'h8F);
    acc(4);
    load(20, 10);
    q.push_back(40);
    go(0);
    chk("gap_ad", int'(ad), 10);
    acc(1); tick; acc(1); tick;
    chk("gap_sad_mid", int'(sad), 20);
    chk("gap_busy_mid", int'(busy), 1);
    acc(2);
    chk("gap_valid", int'(sad_valid), 1);
    tick;
    q.push_back(40);
    go(0);
    acc(2);
    go(0);
    chk("restart_sad", int'(sad), 0);
    chk("restart_busy", int'(busy), 1);
    acc(4);
    tick;
    load(255, 0);
    q.push_back(1020);
    go(0);
    acc(4);
    chk("sat_sad", int'(s_sad), 511);
    acc(3);
    chk("sat_hold_idle", int'(s_sad), 511);
    chk("full_hold_idle", int'(sad), 1020);
    load(200, 50);
    go(0);
    acc(2);
    mode = 2;
    tick;
    chk("mode_change_ad", int'(ad), 150);
    #3 rst_n = 0;
    #1;
    chk("arst_sad", int'(sad), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_valid", int'(sad_valid), 0);
    chk("arst_nxt", int'({nxt_sw, nxt_tb}), 0);
    chk("arst_ad", int'(ad), 0);
    tick;
    rst_n = 1;
    tick;
    acc(5);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_sad", int'(sad), 0);
    tick;
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/pe_sad.md
PE_SAD -- requirements
Module: pe_sad

Interface
REQ-001 SHALL have parameter PW, default 8: pixel width in bits, legal range 4..16 and even.
REQ-002 SHALL have parameter NPIX, default 256: pixels per block SAD, legal range 2..65536.
REQ-003 SHALL have parameter SADW, default 16: SAD accumulator width, at least PW+clog2(NPIX) for non-saturating full-mode use.
REQ-004 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have ports en_sw, en_tb, input, 1 each: load enables for the search-window and template-block registers.
REQ-007 SHALL have ports pel_sw, pel_tb, input, PW each: incoming search-window and template pixels.
REQ-008 SHALL have ports nxt_sw, nxt_tb, output, PW each: registered pixels, forwarded to the neighbouring PE.
REQ-009 SHALL have port mode, input, 2: distance metric, sampled only when start is accepted.
REQ-010 SHALL have ports start and acc_en, input, 1 each: start a block SAD; accumulate this cycle.
REQ-011 SHALL have port ad, output, PW: combinational distance of nxt_sw and nxt_tb under the active mode.
REQ-012 SHALL have ports sad (output, SADW), sad_valid (output, 1) and busy (output, 1): accumulated SAD; one-cycle completion pulse; accumulation in progress.

Function
REQ-013 SHALL load nxt_sw<=pel_sw when en_sw=1 and nxt_tb<=pel_tb when en_tb=1; otherwise each register holds.
REQ-014 SHALL use mode 0 (full): ad = |nxt_sw - nxt_tb| over PW bits.
REQ-015 SHALL use mode 1 (MSB half): ad = |nxt_sw[PW-1:PW/2] - nxt_tb[PW-1:PW/2]|, zero-extended to PW.
REQ-016 SHALL use mode 2 (hybrid): ad[PW-1:PW-2] = |2 MSBs difference| and ad[PW-3:0] = nxt_sw[PW-3:0] XOR nxt_tb[PW-3:0].
REQ-017 SHALL treat mode 3 as mode 0.
REQ-018 SHALL select the ad metric from the latched mode register (reset value 0), not directly from the mode port.
REQ-019 SHALL implement FSM states IDLE (reset state) and ACC, with busy=1 exactly in ACC.
REQ-020 SHALL, on start=1 in any state: latch mode, set sad<=0 and count<=0, enter ACC, and ignore acc_en on that edge.
REQ-021 SHALL, in ACC with acc_en=1 and start=0: set sad<=min(sad+ad, 2^SADW-1) and count<=count+1.
REQ-022 SHALL, on the ACC edge where count==NPIX-1 and acc_en=1: perform the final add, return to IDLE and assert sad_valid for exactly the next cycle.
REQ-023 SHALL leave sad and count unchanged in ACC when acc_en=0.
REQ-024 SHALL ignore acc_en in IDLE and hold sad until the next start.
REQ-025 SHALL restart the block when start is asserted during ACC (REQ-020); the interrupted SAD produces no sad_valid.
REQ-026 SHALL saturate sad at 2^SADW-1 and keep it saturated to block end without wrapping.
REQ-027 SHALL use a count register of clog2(NPIX)+1 bits; count never exceeds NPIX-1.
REQ-028 SHALL compute ad from the register values present before the edge, so pixels loaded on edge k accumulate on edge k+1 or later.

Reset
REQ-029 SHALL, on rst_n=0, immediately force nxt_sw=0, nxt_tb=0, sad=0, count=0, latched mode=0, sad_valid=0, busy=0 and state IDLE, independent of clk.
REQ-030 SHALL abandon any accumulation in progress on reset, with no sad_valid issued.
REQ-031 SHALL resume operation on the first clk edge after rst_n deasserts, requiring a new start to accumulate.

Verification (NPIX=4, PW=8, SADW=16 bench)
REQ-032 SHALL cover mode 0: sw=200, tb=50 -> ad=150; start, then four acc_en cycles -> sad=600, sad_valid one cycle, busy falls.
REQ-033 SHALL cover mode 1: sw=0xF3, tb=0x1C -> ad=0x0E; and mode 2: sw=0xC5, tb=0x4A -> ad=0x8F.
REQ-034 SHALL cover acc_en gaps: pattern 1,0,1,0,1,1 with ad=10 -> sad=40, sad_valid after the 4th accumulation only.
REQ-035 SHALL cover restart: start again after 2 accumulations -> sad=0, no sad_valid; four more accumulations -> normal completion.
REQ-036 SHALL cover saturation: SADW=9, ad=255 for 4 cycles -> sad=511, held until the next start.
REQ-037 SHALL cover async reset mid-ACC: all outputs 0, busy=0, no sad_valid; mode change during ACC does not alter ad.
